spi_slave_cfg: RTL and testbench

Parametrised SPI slave for the peripheral side of the SPI interface. It supports a configurable word width, all four SPI modes selected at runtime, and MSB- or LSB-first ordering. Both directions use valid/ready handshakes, with a one-word TX holding register and a one-word RX output register. Multi-word frames are supported under a single ss_n assertion, with underrun and overrun reporting. All SPI pins are asynchronous to clk and are oversampled in the clk domain.

---
 rtl/spi_slave_cfg_if.sv | 32 +++
 rtl/spi_slave_cfg.sv | 219 +++++++++++++++++++++
 tb/tb_spi_slave_cfg.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_cfg_if.sv
// Bus bundle for spi_slave_cfg: SPI pins, mode selects, TX/RX valid-ready streams and status.
// The slave modport is the peripheral's view; master is the view of whatever drives it.
interface spi_slave_cfg_if #(
  parameter int DATA_W = 8
);
  logic              ss_n;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic              cpol;
  logic              cpha;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              busy;
  logic              tx_underrun;
  logic              rx_overrun;

  modport slave (
    input  ss_n, sck, mosi, cpol, cpha, tx_data, tx_valid, rx_ready,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overrun
  );

  modport master (
    output ss_n, sck, mosi, cpol, cpha, tx_data, tx_valid, rx_ready,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, tx_underrun, rx_overrun
  );
endinterface

// File: rtl/spi_slave_cfg.sv
// Oversampling SPI slave: runtime-selectable mode, MSB/LSB-first, one-word TX holding register
// and one-word RX output register with underrun/overrun pulses.
module spi_slave_cfg #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LSB_FIRST   = 0
) (
  input logic            clk,
  input logic            rst,
  spi_slave_cfg_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam bit LSB_F = LSB_FIRST[0];

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    if (LSB_F) first_bit = w[0];
    else       first_bit = w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] pop_word(input logic [DATA_W-1:0] w);
    if (LSB_F) pop_word = {1'b0, w[DATA_W-1:1]};
    else       pop_word = {w[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] w, input logic b);
    if (LSB_F) push_bit = {b, w[DATA_W-1:1]};
    else       push_bit = {w[DATA_W-2:0], b};
  endfunction

  logic [SYNC_STAGES-1:0] ss_sync_r, sck_sync_r, mosi_sync_r;
  logic                   ss_d_r, sck_d_r;
  logic                   ss_s, sck_s, mosi_s;
  logic                   ss_fall_s, sck_rise_s, sck_fall_s, lead_s, trail_s;

  state_t                 state_r, state_next_s;
  logic                   start_s, sample_s, shift_s, word_done_s, load_s, tx_fire_s;

  logic                   cpol_r, cpha_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [DATA_W-1:0]      tx_shift_r, rx_shift_r, hold_r;
  logic [DATA_W-1:0]      load_word_s, rx_word_s, rx_data_r;
  logic                   hold_empty_r, zero_word_r;
  logic                   miso_r, miso_oe_r, busy_r, rx_valid_r, tx_underrun_r, rx_overrun_r;

  // Pin synchronisers plus one delayed copy of ss_n and sck for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync_r   <= '0;
      sck_sync_r  <= '0;
      mosi_sync_r <= '0;
      ss_d_r      <= 1'b0;
      sck_d_r     <= 1'b0;
    end else begin
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], bus.ss_n};
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], bus.sck};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi};
      ss_d_r      <= ss_s;
      sck_d_r     <= sck_s;
    end
  end

  assign ss_s       = ss_sync_r[SYNC_STAGES-1];
  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  // Synchronisers clear to low, so a frame only starts after ss_n has been seen high again.
  assign ss_fall_s  = ss_d_r & ~ss_s;
  assign sck_rise_s = sck_s & ~sck_d_r;
  assign sck_fall_s = ~sck_s & sck_d_r;
  assign lead_s     = cpol_r ? sck_fall_s : sck_rise_s;
  assign trail_s    = cpol_r ? sck_rise_s : sck_fall_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   if (ss_fall_s) state_next_s = ST_ACTIVE; else state_next_s = ST_IDLE;
      ST_ACTIVE: if (ss_s)      state_next_s = ST_IDLE;   else state_next_s = ST_ACTIVE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // FSM output decode: frame start and per-edge strobes
  always_comb begin
    start_s  = 1'b0;
    sample_s = 1'b0;
    shift_s  = 1'b0;
    case (state_r)
      ST_IDLE: start_s = ss_fall_s;
      ST_ACTIVE: begin
        if (!ss_s) begin
          sample_s = cpha_r ? trail_s : lead_s;
          shift_s  = cpha_r ? lead_s  : trail_s;
        end else begin
          sample_s = 1'b0;
          shift_s  = 1'b0;
        end
      end
      default: start_s = 1'b0;
    endcase
  end

  assign word_done_s = sample_s & (bit_cnt_r == CNT_W'(DATA_W - 1));
  assign load_s      = start_s | word_done_s;
  assign load_word_s = hold_empty_r ? '0 : hold_r;
  assign tx_fire_s   = bus.tx_valid & hold_empty_r;
  assign rx_word_s   = push_bit(rx_shift_r, mosi_s);

  // Mode latch, captured only at frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      cpol_r <= 1'b0;
      cpha_r <= 1'b0;
    end else if (start_s) begin
      cpol_r <= bus.cpol;
      cpha_r <= bus.cpha;
    end
  end

  // Shift registers, bit counter and miso driver
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift_r  <= '0;
      rx_shift_r  <= '0;
      bit_cnt_r   <= '0;
      zero_word_r <= 1'b0;
      miso_r      <= 1'b0;
    end else if (start_s) begin
      bit_cnt_r   <= '0;
      zero_word_r <= hold_empty_r;
      if (!bus.cpha) begin
        miso_r     <= first_bit(load_word_s);
        tx_shift_r <= pop_word(load_word_s);
      end else begin
        tx_shift_r <= load_word_s;
      end
    end else if (sample_s) begin
      rx_shift_r <= rx_word_s;
      if (word_done_s) begin
        bit_cnt_r   <= '0;
        tx_shift_r  <= load_word_s;
        zero_word_r <= hold_empty_r;
      end else begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end
    end else if (shift_s) begin
      miso_r     <= first_bit(tx_shift_r);
      tx_shift_r <= pop_word(tx_shift_r);
    end else if (state_r == ST_IDLE) begin
      miso_r <= 1'b0;
    end
  end

  // TX holding register; a load and a write in the same cycle hand over old and new word
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r       <= '0;
      hold_empty_r <= 1'b1;
    end else if (load_s) begin
      hold_empty_r <= ~tx_fire_s;
      if (tx_fire_s) hold_r <= bus.tx_data;
    end else if (tx_fire_s) begin
      hold_r       <= bus.tx_data;
      hold_empty_r <= 1'b0;
    end
  end

  // RX output register and status pulses; underrun fires when a zero-filled word is first clocked
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_r     <= '0;
      rx_valid_r    <= 1'b0;
      rx_overrun_r  <= 1'b0;
      tx_underrun_r <= 1'b0;
    end else begin
      rx_overrun_r  <= 1'b0;
      tx_underrun_r <= sample_s & zero_word_r & (bit_cnt_r == '0);
      if (word_done_s) begin
        if (rx_valid_r && !bus.rx_ready) begin
          rx_overrun_r <= 1'b1;
        end else begin
          rx_data_r  <= rx_word_s;
          rx_valid_r <= 1'b1;
        end
      end else if (rx_valid_r && bus.rx_ready) begin
        rx_valid_r <= 1'b0;
      end
    end
  end

  // Frame-in-progress flags
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r    <= 1'b0;
      miso_oe_r <= 1'b0;
    end else begin
      busy_r    <= (state_next_s == ST_ACTIVE);
      miso_oe_r <= (state_next_s == ST_ACTIVE);
    end
  end

  assign bus.miso        = miso_r;
  assign bus.miso_oe     = miso_oe_r;
  assign bus.tx_ready    = hold_empty_r;
  assign bus.rx_data     = rx_data_r;
  assign bus.rx_valid    = rx_valid_r;
  assign bus.busy        = busy_r;
  assign bus.tx_underrun = tx_underrun_r;
  assign bus.rx_overrun  = rx_overrun_r;

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Directed bench for spi_slave_cfg: an 8-bit MSB-first and a 16-bit LSB-first instance share sck/mosi,
// each with its own ss_n; a behavioural SPI master exchanges words and every result is hand-computed.
module tb_spi_slave_cfg;
  localparam int H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        ss8_n, ss16_n, sck, mosi, cpol, cpha;
  logic [7:0]  tx_data8;
  logic        tx_valid8, rx_ready8;
  logic [15:0] tx_data16;
  logic        tx_valid16, rx_ready16;
  logic        m_cpol, m_cpha;
  logic [15:0] m_out [4];
  logic [15:0] m_in  [4];
  int          checks = 0;
  int          errors = 0;

  spi_slave_cfg_if #(.DATA_W(8))  bus8 ();
  spi_slave_cfg_if #(.DATA_W(16)) bus16 ();

  assign bus8.ss_n      = ss8_n;
  assign bus8.sck       = sck;
  assign bus8.mosi      = mosi;
  assign bus8.cpol      = cpol;
  assign bus8.cpha      = cpha;
  assign bus8.tx_data   = tx_data8;
  assign bus8.tx_valid  = tx_valid8;
  assign bus8.rx_ready  = rx_ready8;
  assign bus16.ss_n     = ss16_n;
  assign bus16.sck      = sck;
  assign bus16.mosi     = mosi;
  assign bus16.cpol     = cpol;
  assign bus16.cpha     = cpha;
  assign bus16.tx_data  = tx_data16;
  assign bus16.tx_valid = tx_valid16;
  assign bus16.rx_ready = rx_ready16;

  spi_slave_cfg #(.DATA_W(8), .SYNC_STAGES(2), .LSB_FIRST(0)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  spi_slave_cfg #(.DATA_W(16), .SYNC_STAGES(2), .LSB_FIRST(1)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int         und8 = 0;
  int         ovr8 = 0;
  int         rxn8 = 0;
  logic [7:0] rxlog8 [16];

  always @(posedge clk) begin
    if (bus8.tx_underrun) und8 <= und8 + 1;
    if (bus8.rx_overrun)  ovr8 <= ovr8 + 1;
    if (bus8.rx_valid && rx_ready8 && rxn8 < 16) begin
      rxlog8[rxn8] <= bus8.rx_data;
      rxn8         <= rxn8 + 1;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input bit t16, input logic [15:0] d);
    int t = 0;
    while (((t16 ? bus16.tx_ready : bus8.tx_ready) !== 1'b1) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if ((t16 ? bus16.tx_ready : bus8.tx_ready) !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_wait: tx_ready=%b required 1", t16 ? bus16.tx_ready : bus8.tx_ready);
    end
    if (t16) begin tx_data16 = d; tx_valid16 = 1'b1; end
    else begin tx_data8 = d[7:0]; tx_valid8 = 1'b1; end
    @(negedge clk);
    tx_valid8  = 1'b0;
    tx_valid16 = 1'b0;
  endtask

  task automatic wait_busy(input bit t16);
    int t = 0;
    while (((t16 ? bus16.busy : bus8.busy) !== 1'b1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if ((t16 ? bus16.busy : bus8.busy) !== 1'b1) begin
      errors++;
      $display("FAIL busy_wait: busy=%b required 1", t16 ? bus16.busy : bus8.busy);
    end
  endtask

  task automatic consume(input bit t16);
    if (t16) rx_ready16 = 1'b1; else rx_ready8 = 1'b1;
    @(negedge clk);
    rx_ready8  = 1'b0;
    rx_ready16 = 1'b0;
    @(negedge clk);
  endtask

  // Behavioural master: mosi driven on its shift edge, miso captured on its sample edge.
  task automatic spi_frame(input bit t16, input int nwords, input int abort_at);
    int w, pos, cnt;
    bit stop;
    w = t16 ? 16 : 8;
    cnt = 0;
    stop = 1'b0;
    sck = m_cpol;
    mosi = 1'b0;
    for (int i = 0; i < 4; i++) m_in[i] = 16'h0000;
    wait_clk(H);
    if (t16) ss16_n = 1'b0; else ss8_n = 1'b0;
    wait_clk(H);
    for (int wi = 0; wi < nwords && !stop; wi++) begin
      for (int b = 0; b < w && !stop; b++) begin
        pos = t16 ? b : (w - 1 - b);
        if (abort_at != 0 && cnt == abort_at) begin
          stop = 1'b1;
        end else begin
          if (!m_cpha) begin
            mosi = m_out[wi][pos];
            wait_clk(H);
            sck = ~sck;
            m_in[wi][pos] = t16 ? bus16.miso : bus8.miso;
            wait_clk(H);
            sck = ~sck;
          end else begin
            sck = ~sck;
            mosi = m_out[wi][pos];
            wait_clk(H);
            sck = ~sck;
            m_in[wi][pos] = t16 ? bus16.miso : bus8.miso;
            wait_clk(H);
          end
          cnt++;
        end
      end
    end
    wait_clk(H);
    ss8_n = 1'b1;
    ss16_n = 1'b1;
    wait_clk(2 * H);
  endtask

  task automatic test_reset();
    checks++;
    if ({bus8.miso, bus8.miso_oe, bus8.tx_ready, bus8.rx_valid, bus8.busy, bus8.tx_underrun, bus8.rx_overrun} !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_flags8: got %b want 0010000", {bus8.miso, bus8.miso_oe, bus8.tx_ready, bus8.rx_valid, bus8.busy, bus8.tx_underrun, bus8.rx_overrun});
    end
    checks++;
    if (bus8.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data8: got %h want 00", bus8.rx_data); end
    checks++;
    if ({bus16.miso, bus16.miso_oe, bus16.tx_ready, bus16.rx_valid, bus16.busy, bus16.tx_underrun, bus16.rx_overrun} !== 7'b0010000) begin
      errors++;
      $display("FAIL reset_flags16: got %b want 0010000", {bus16.miso, bus16.miso_oe, bus16.tx_ready, bus16.rx_valid, bus16.busy, bus16.tx_underrun, bus16.rx_overrun});
    end
    checks++;
    if (bus16.rx_data !== 16'h0000) begin errors++; $display("FAIL reset_rx_data16: got %h want 0000", bus16.rx_data); end
  endtask

  task automatic test_mode0();
    int u0;
    m_cpol = 1'b0; m_cpha = 1'b0; cpol = 1'b0; cpha = 1'b0;
    write_tx(1'b0, 16'h003C);
    m_out[0] = 16'h00A5;
    u0 = und8;
    spi_frame(1'b0, 1, 0);
    checks++;
    if (m_in[0][7:0] !== 8'h3C) begin errors++; $display("FAIL mode0_miso: got %h want 3c", m_in[0][7:0]); end
    checks++;
    if (bus8.rx_data !== 8'hA5) begin errors++; $display("FAIL mode0_rx_data: got %h want a5", bus8.rx_data); end
    checks++;
    if (bus8.rx_valid !== 1'b1) begin errors++; $display("FAIL mode0_rx_valid: got %b want 1", bus8.rx_valid); end
    checks++;
    if (und8 - u0 !== 0) begin errors++; $display("FAIL mode0_underrun: got %0d pulses want 0", und8 - u0); end
    consume(1'b0);
    checks++;
    if (bus8.rx_valid !== 1'b0) begin errors++; $display("FAIL mode0_consume: rx_valid=%b want 0", bus8.rx_valid); end
  endtask

  task automatic test_modes();
    for (int m = 1; m < 4; m++) begin
      m_cpol = m[1]; m_cpha = m[0]; cpol = m[1]; cpha = m[0];
      write_tx(1'b0, 16'h005A);
      m_out[0] = 16'h00C3;
      fork
        spi_frame(1'b0, 1, 0);
        begin
          wait_busy(1'b0);
          wait_clk(20);
          cpol = ~m_cpol;
          cpha = ~m_cpha;
        end
      join
      cpol = m_cpol; cpha = m_cpha;
      checks++;
      if (m_in[0][7:0] !== 8'h5A) begin errors++; $display("FAIL mode%0d_miso: got %h want 5a", m, m_in[0][7:0]); end
      checks++;
      if (bus8.rx_data !== 8'hC3) begin errors++; $display("FAIL mode%0d_rx_data: got %h want c3", m, bus8.rx_data); end
      checks++;
      if (bus8.rx_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_rx_valid: got %b want 1", m, bus8.rx_valid); end
      consume(1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int n0, u0, o0;
    m_cpol = 1'b0; m_cpha = 1'b0; cpol = 1'b0; cpha = 1'b0;
    write_tx(1'b0, 16'h00A1);
    m_out[0] = 16'h0011; m_out[1] = 16'h0022; m_out[2] = 16'h0033;
    n0 = rxn8; u0 = und8; o0 = ovr8;
    rx_ready8 = 1'b1;
    fork
      spi_frame(1'b0, 3, 0);
      begin
        write_tx(1'b0, 16'h00B2);
        write_tx(1'b0, 16'h00C3);
      end
    join
    rx_ready8 = 1'b0;
    checks++;
    if (rxn8 - n0 !== 3) begin errors++; $display("FAIL b2b_rx_count: got %0d want 3", rxn8 - n0); end
    checks++;
    if ({rxlog8[n0], rxlog8[n0+1], rxlog8[n0+2]} !== 24'h112233) begin
      errors++;
      $display("FAIL b2b_rx_words: got %h %h %h want 11 22 33", rxlog8[n0], rxlog8[n0+1], rxlog8[n0+2]);
    end
    checks++;
    if ({m_in[0][7:0], m_in[1][7:0], m_in[2][7:0]} !== 24'hA1B2C3) begin
      errors++;
      $display("FAIL b2b_miso_words: got %h %h %h want a1 b2 c3", m_in[0][7:0], m_in[1][7:0], m_in[2][7:0]);
    end
    checks++;
    if ((und8 - u0) !== 0 || (ovr8 - o0) !== 0) begin
      errors++;
      $display("FAIL b2b_flags: underruns %0d overruns %0d want 0 0", und8 - u0, ovr8 - o0);
    end
  endtask

  task automatic test_underrun_overrun();
    int u0, o0;
    m_cpol = 1'b0; m_cpha = 1'b0;
    m_out[0] = 16'h0081; m_out[1] = 16'h0042;
    u0 = und8; o0 = ovr8;
    fork
      spi_frame(1'b0, 2, 0);
      begin
        wait_busy(1'b0);
        write_tx(1'b0, 16'h007E);
      end
    join
    checks++;
    if ({m_in[0][7:0], m_in[1][7:0]} !== 16'h007E) begin
      errors++;
      $display("FAIL urun_miso: got %h %h want 00 7e", m_in[0][7:0], m_in[1][7:0]);
    end
    checks++;
    if (und8 - u0 !== 1) begin errors++; $display("FAIL urun_pulses: got %0d want 1", und8 - u0); end
    checks++;
    if (ovr8 - o0 !== 1) begin errors++; $display("FAIL orun_pulses: got %0d want 1", ovr8 - o0); end
    checks++;
    if ({bus8.rx_valid, bus8.rx_data} !== 9'h181) begin
      errors++;
      $display("FAIL orun_rx_kept: got valid=%b data=%h want 1 81", bus8.rx_valid, bus8.rx_data);
    end
    consume(1'b0);
  endtask

  task automatic test_abort();
    m_cpol = 1'b0; m_cpha = 1'b0;
    m_out[0] = 16'h00FF;
    fork
      spi_frame(1'b0, 1, 5);
      begin
        wait_busy(1'b0);
        checks++;
        if (bus8.miso_oe !== 1'b1) begin errors++; $display("FAIL abort_oe_active: got %b want 1", bus8.miso_oe); end
      end
    join
    checks++;
    if ({bus8.rx_valid, bus8.miso_oe, bus8.busy} !== 3'b000) begin
      errors++;
      $display("FAIL abort_idle: rx_valid/miso_oe/busy=%b want 000", {bus8.rx_valid, bus8.miso_oe, bus8.busy});
    end
    write_tx(1'b0, 16'h0069);
    m_out[0] = 16'h0096;
    spi_frame(1'b0, 1, 0);
    checks++;
    if ({bus8.rx_valid, bus8.rx_data} !== 9'h196) begin
      errors++;
      $display("FAIL abort_next_rx: got valid=%b data=%h want 1 96", bus8.rx_valid, bus8.rx_data);
    end
    checks++;
    if (m_in[0][7:0] !== 8'h69) begin errors++; $display("FAIL abort_next_miso: got %h want 69", m_in[0][7:0]); end
    consume(1'b0);
  endtask

  task automatic test_lsb16();
    m_cpol = 1'b0; m_cpha = 1'b0; cpol = 1'b0; cpha = 1'b0;
    write_tx(1'b1, 16'hBEEF);
    m_out[0] = 16'h1234;
    spi_frame(1'b1, 1, 0);
    checks++;
    if (m_in[0] !== 16'hBEEF) begin errors++; $display("FAIL lsb16_miso: got %h want beef", m_in[0]); end
    checks++;
    if ({bus16.rx_valid, bus16.rx_data} !== 17'h11234) begin
      errors++;
      $display("FAIL lsb16_rx: got valid=%b data=%h want 1 1234", bus16.rx_valid, bus16.rx_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    write_tx(1'b1, 16'hA5A5);
    m_out[0] = 16'h5555;
    fork
      spi_frame(1'b1, 1, 0);
      begin
        wait_busy(1'b1);
        wait_clk(40);
        rst = 1'b1;
        wait_clk(2);
        checks++;
        if ({bus16.miso, bus16.miso_oe, bus16.tx_ready, bus16.rx_valid, bus16.busy, bus16.tx_underrun, bus16.rx_overrun} !== 7'b0010000) begin
          errors++;
          $display("FAIL midrst_flags: got %b want 0010000", {bus16.miso, bus16.miso_oe, bus16.tx_ready, bus16.rx_valid, bus16.busy, bus16.tx_underrun, bus16.rx_overrun});
        end
        checks++;
        if (bus16.rx_data !== 16'h0000) begin errors++; $display("FAIL midrst_rx_data: got %h want 0000", bus16.rx_data); end
        rst = 1'b0;
      end
    join
    checks++;
    if ({bus16.rx_valid, bus16.busy, bus16.miso_oe} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_stays_idle: rx_valid/busy/miso_oe=%b want 000", {bus16.rx_valid, bus16.busy, bus16.miso_oe});
    end
    write_tx(1'b1, 16'h0F0F);
    m_out[0] = 16'hF00D;
    spi_frame(1'b1, 1, 0);
    checks++;
    if ({bus16.rx_data, m_in[0]} !== 32'hF00D0F0F) begin
      errors++;
      $display("FAIL midrst_recover: rx_data=%h miso_word=%h want f00d 0f0f", bus16.rx_data, m_in[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    ss8_n = 1'b1; ss16_n = 1'b1; sck = 1'b0; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    tx_data8 = 8'h00; tx_valid8 = 1'b0; rx_ready8 = 1'b0;
    tx_data16 = 16'h0000; tx_valid16 = 1'b0; rx_ready16 = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0;
    for (int i = 0; i < 4; i++) begin m_out[i] = 16'h0000; m_in[i] = 16'h0000; end
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_underrun_overrun();
    test_abort();
    test_lsb16();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
